// File: rtl/mult_hilo_unit_pkg.sv
// Shared types and constants for the HI/LO multiply writeback stage.
package mult_hilo_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 64;

  // Sequencer states: accept, multiply, write back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude of the most negative operand.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_hilo_unit_mult32.sv
// Unsigned 32x32 -> 64 array multiplier core. Output is forced to zero while
// mult is low so nothing undefined can leak into downstream registers.
module mult_hilo_unit_mult32
  import mult_hilo_unit_pkg::*;
(
  input  logic              mult,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] out,
  output logic              en
);

  // Combinational product, qualified by mult.
  always_comb begin
    out = mult ? (PROD_W'(a) * PROD_W'(b)) : '0;
    en  = mult;
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// Multiply sequencing/writeback stage: accepts a request, multiplies operand
// magnitudes through the mult32 core, fixes up the sign and commits to HI/LO.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter logic [31:0] HI_RST = 32'h0000_0000,
  parameter logic [31:0] LO_RST = 32'h0000_0000
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              flush,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                neg_q, neg_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                mult_on;
  logic [PROD_W-1:0]   mult_out;
  logic                mult_en_unused;
  logic [PROD_W-1:0]   res;
  logic                done_c;

  mult_hilo_unit_mult32 u_mult32 (
    .mult (mult_on),
    .a    (a_q),
    .b    (b_q),
    .out  (mult_out),
    .en   (mult_en_unused)
  );

  // Next-state, datapath and output decode for the IDLE/MUL/WB sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mult_on = 1'b0;
    done_c  = 1'b0;
    res     = neg_q ? (~prod_q + PROD_W'(1)) : prod_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (req_valid && !flush) begin
          a_d     = req_signed ? magnitude(req_a) : req_a;
          b_d     = req_signed ? magnitude(req_b) : req_b;
          neg_d   = req_signed & (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        mult_on = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          prod_d  = mult_out;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d   = res[PROD_W-1:DATA_W];
          lo_d   = res[DATA_W-1:0];
          done_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs; pulses are suppressed while reset is held.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && !flush;
    busy      = (state_q != ST_IDLE);
    done      = done_c && p_reset;
    cmd_err   = busy && (mthi || mtlo) && p_reset;
    hi        = hi_q;
    lo        = lo_q;
  end

  // State register with synchronous active-low reset that overrides all inputs.
  always_ff @(posedge m_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!p_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      hi_q    <= HI_RST;
      lo_q    <= LO_RST;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Randomized self-checking bench for mult_hilo_unit with an arithmetic model.
module tb_mult_hilo_unit;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        req_valid, req_signed, flush, mthi, mtlo;
  logic [31:0] req_a, req_b, wdata;
  logic        req_ready, busy, done, cmd_err;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi, m_lo;

  always #5 m_clock = ~m_clock;

  mult_hilo_unit #(.HI_RST(32'h0), .LO_RST(32'h0)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit product of the operands as signed or unsigned integers.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic clear_inputs();
    req_valid = 0; req_signed = 0; req_a = 0; req_b = 0;
    flush = 0; mthi = 0; mtlo = 0; wdata = 0;
  endtask

  // Full operation: present at a negedge, expect done two negedges later and
  // HI/LO committed at the edge ending the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int cyc;
    bit found;
    @(negedge m_clock);
    req_valid = 1; req_a = a; req_b = b; req_signed = sgn;
    #1 check("op_ready", 64'(req_ready), 64'd1);
    @(negedge m_clock);
    clear_inputs();
    cyc = 1;
    found = 0;
    while (cyc < 6) begin
      #1;
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge m_clock);
      cyc++;
    end
    check("op_done_seen", 64'(found), 64'd1);
    check("op_done_lat", 64'(cyc), 64'd2);
    {m_hi, m_lo} = ref_product(a, b, sgn);
    @(negedge m_clock);
    #1;
    check("op_hi", 64'(hi), 64'(m_hi));
    check("op_lo", 64'(lo), 64'(m_lo));
    check("op_done_clr", 64'(done), 64'd0);
    check("op_ready_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] corners [6];
    logic [31:0] ra, rb;
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0001_0000;

    clear_inputs();
    p_reset = 0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(negedge m_clock);
    #1;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge m_clock);
    p_reset = 1;
    #1 check("rst_ready", 64'(req_ready), 64'd1);

    // Directed products with literal expectations.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("t1_hi", 64'(hi), 64'hFFFF_FFFE);
    check("t1_lo", 64'(lo), 64'h0000_0001);
    run_op(32'hFFFF_FFFF, 32'h1, 1'b1);
    check("t2s_hi", 64'(hi), 64'hFFFF_FFFF);
    check("t2s_lo", 64'(lo), 64'hFFFF_FFFF);
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    check("t2u_hi", 64'(hi), 64'h0);
    check("t2u_lo", 64'(lo), 64'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    check("t3a_hi", 64'(hi), 64'h4000_0000);
    check("t3a_lo", 64'(lo), 64'h0);
    run_op(32'h8000_0000, 32'h1, 1'b1);
    check("t3b_hi", 64'(hi), 64'hFFFF_FFFF);
    check("t3b_lo", 64'(lo), 64'h8000_0000);

    // Flush in MUL: no done, HI/LO keep previous values.
    @(negedge m_clock);
    req_valid = 1; req_a = 7; req_b = 6;
    @(negedge m_clock);
    clear_inputs(); flush = 1;
    #1 check("fl_mul_busy", 64'(busy), 64'd1);
    check("fl_mul_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge m_clock);
      clear_inputs();
      #1 check("fl_mul_nodone", 64'(done), 64'd0);
      check("fl_mul_hi", 64'(hi), 64'(m_hi));
      check("fl_mul_lo", 64'(lo), 64'(m_lo));
    end
    run_op(32'd3, 32'd5, 1'b0);
    check("t4_lo", 64'(lo), 64'd15);

    // Flush in WB: done suppressed and no commit.
    @(negedge m_clock);
    req_valid = 1; req_a = 9; req_b = 9;
    @(negedge m_clock);
    clear_inputs();
    @(negedge m_clock);
    flush = 1;
    #1 check("fl_wb_done", 64'(done), 64'd0);
    @(negedge m_clock);
    clear_inputs();
    #1 check("fl_wb_lo", 64'(lo), 64'(m_lo));
    check("fl_wb_idle", 64'(busy), 64'd0);

    // Flush in IDLE blocks a simultaneous request.
    @(negedge m_clock);
    req_valid = 1; req_a = 2; req_b = 2; flush = 1;
    #1 check("fl_idle_ready", 64'(req_ready), 64'd0);
    @(negedge m_clock);
    clear_inputs();
    #1 check("fl_idle_busy", 64'(busy), 64'd0);

    // mthi while busy is dropped with cmd_err; mtlo in IDLE lands next edge.
    @(negedge m_clock);
    req_valid = 1; req_a = 4; req_b = 5;
    @(negedge m_clock);
    clear_inputs(); mthi = 1; wdata = 32'h1234;
    #1 check("t5_cmd_err", 64'(cmd_err), 64'd1);
    @(negedge m_clock);
    clear_inputs();
    #1 check("t5_cmd_err_clr", 64'(cmd_err), 64'd0);
    {m_hi, m_lo} = ref_product(32'd4, 32'd5, 1'b0);
    @(negedge m_clock);
    #1 check("t5_hi_kept", 64'(hi), 64'(m_hi));
    mtlo = 1; wdata = 32'hABCD;
    #1 check("t5_idle_noerr", 64'(cmd_err), 64'd0);
    @(negedge m_clock);
    clear_inputs();
    #1 check("t5_lo", 64'(lo), 64'hABCD);
    m_lo = 32'hABCD;

    // mthi+mtlo alongside a request: write now, product overwrites at WB.
    @(negedge m_clock);
    mthi = 1; mtlo = 1; wdata = 32'h5555_AAAA;
    req_valid = 1; req_a = 32'hFFFF_FFFE; req_b = 32'd3; req_signed = 1;
    @(negedge m_clock);
    clear_inputs();
    #1 check("wr_req_hi", 64'(hi), 64'h5555_AAAA);
    check("wr_req_lo", 64'(lo), 64'h5555_AAAA);
    {m_hi, m_lo} = ref_product(32'hFFFF_FFFE, 32'd3, 1'b1);
    repeat (2) @(negedge m_clock);
    #1 check("wr_req_phi", 64'(hi), 64'(m_hi));
    check("wr_req_plo", 64'(lo), 64'(m_lo));

    // Reset during WB: no done, HI/LO return to reset values.
    @(negedge m_clock);
    req_valid = 1; req_a = 2; req_b = 3;
    @(negedge m_clock);
    clear_inputs();
    @(negedge m_clock);
    p_reset = 0;
    #1 check("t6_done", 64'(done), 64'd0);
    @(negedge m_clock);
    p_reset = 1;
    #1 check("t6_hi", 64'(hi), 64'h0);
    check("t6_lo", 64'(lo), 64'h0);
    check("t6_ready", 64'(req_ready), 64'd1);
    m_hi = 0; m_lo = 0;

    // Randomized operations mixing corner values and random words.
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
